// File: rtl/rv32_div_pkg.sv
// Shared definitions for the RV32 divider: op codes, FSM states and the
// fixed-point scaling shared with the ALU's FXMUL path.
package rv32_div_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OpFxdiv = 3'b000;
   localparam op_t OpDiv   = 3'b100;
   localparam op_t OpDivu  = 3'b101;
   localparam op_t OpRem   = 3'b110;
   localparam op_t OpRemu  = 3'b111;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StCalc = 2'd1;
   localparam state_t StFix  = 2'd2;
   localparam state_t StDone = 2'd3;

   // Q17.14 scaling; FXMUL and FXDIV both take this value.
   localparam int unsigned FxFracBits = 14;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/rv32_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and fixed-point FXDIV,
// one quotient bit per clock.
module rv32_divider
   import rv32_div_pkg::*;
#(
   parameter int unsigned FX_FRAC_BITS = FxFracBits
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_in,
   input  logic [2:0]  op_in,
   input  logic [31:0] dividend_in,
   input  logic [31:0] divisor_in,
   output logic        ready_out,
   output logic        done_out,
   output logic [31:0] result_out
);

   localparam int unsigned DqW  = 32 + FX_FRAC_BITS;
   localparam int unsigned CntW = $clog2(DqW + 1);

   state_t          state_q, state_d;
   logic [31:0]     rem_q, rem_d;
   logic [DqW-1:0]  dq_q, dq_d;
   logic [31:0]     div_q, div_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sa_q, sa_d;
   logic            sb_q, sb_d;
   logic            signed_q, signed_d;
   logic            is_rem_q, is_rem_d;
   logic [31:0]     result_q, result_d;

   logic            op_signed, op_rem, op_fx, b_zero, ovf;
   logic [31:0]     a_mag, b_mag;
   logic [32:0]     rem_sh;
   logic [31:0]     diff;
   logic            borrow;

   always_comb begin
      op_signed = (op_in == OpDiv) || (op_in == OpRem) || (op_in == OpFxdiv);
      op_rem    = (op_in == OpRem) || (op_in == OpRemu);
      op_fx     = (op_in == OpFxdiv);
      b_zero    = (divisor_in == 32'd0);
      ovf       = ((op_in == OpDiv) || (op_in == OpRem)) &&
                  (dividend_in == 32'h8000_0000) && (divisor_in == 32'hFFFF_FFFF);
      a_mag     = op_signed ? abs32(dividend_in) : dividend_in;
      b_mag     = op_signed ? abs32(divisor_in) : divisor_in;

      // Partial remainder never exceeds |b|, so a 32-bit difference is exact
      // whenever there is no borrow.
      rem_sh = {rem_q, dq_q[DqW-1]};
      borrow = rem_sh < {1'b0, div_q};
      diff   = rem_sh[31:0] - div_q;

      state_d  = state_q;
      rem_d    = rem_q;
      dq_d     = dq_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      signed_d = signed_q;
      is_rem_d = is_rem_q;
      result_d = result_q;

      case (state_q)
         StIdle: begin
            if (start_in) begin
               sa_d     = op_signed & dividend_in[31];
               sb_d     = op_signed & divisor_in[31];
               signed_d = op_signed;
               is_rem_d = op_rem;
               if (b_zero) begin
                  if (op_fx) begin
                     result_d = dividend_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                  end else if (op_rem) begin
                     result_d = dividend_in;
                  end else begin
                     result_d = 32'hFFFF_FFFF;
                  end
                  state_d = StDone;
               end else if (ovf) begin
                  result_d = op_rem ? 32'd0 : 32'h8000_0000;
                  state_d  = StDone;
               end else begin
                  // Integer ops run 32 steps over the top word; FXDIV runs all
                  // DqW steps over |a| << FX_FRAC_BITS. Both load the same way.
                  rem_d   = 32'd0;
                  dq_d    = DqW'(a_mag) << FX_FRAC_BITS;
                  div_d   = b_mag;
                  cnt_d   = op_fx ? CntW'(DqW) : CntW'(32);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rem_d = borrow ? rem_sh[31:0] : diff;
            dq_d  = {dq_q[DqW-2:0], ~borrow};
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (is_rem_q) begin
               result_d = (signed_q && sa_q) ? -rem_q : rem_q;
            end else begin
               result_d = (signed_q && (sa_q ^ sb_q)) ? -dq_q[31:0] : dq_q[31:0];
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         dq_q     <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         signed_q <= 1'b0;
         is_rem_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         dq_q     <= dq_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         signed_q <= signed_d;
         is_rem_q <= is_rem_d;
         result_q <= result_d;
      end
   end

   assign ready_out  = (state_q == StIdle);
   assign done_out   = (state_q == StDone);
   assign result_out = result_q;

endmodule
